// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage HI/LO multiply/divide unit.
package mips_pkg;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam int DIV_ITERS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage to multiply/divide unit signal bundle.
interface ex_muldiv_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, flush, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/ex_muldiv_div_iter.sv
// Restoring divider, one quotient bit per clock, sign fix-up on the final step.
module div_iter
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        sgn,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        kill,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        valid
);

   logic [31:0] dvs;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [4:0]  cnt;
   logic        run;
   logic        neg_q;
   logic        neg_r;
   logic        dvz;
   logic [32:0] rem_sh;
   logic [32:0] diff;
   logic        ge;
   logic [31:0] rem_nxt;
   logic [31:0] quo_nxt;

   // Result is taken combinationally from the last step so the top can write on the 32nd edge.
   always_comb begin
      rem_sh    = {rem, quo[31]};
      diff      = rem_sh - {1'b0, dvs};
      ge        = ~diff[32];
      rem_nxt   = ge ? diff[31:0] : rem_sh[31:0];
      quo_nxt   = {quo[30:0], ge};
      valid     = run && (cnt == 5'(DIV_ITERS - 1));
      quotient  = dvz ? 32'hFFFF_FFFF : (neg_q ? -quo_nxt : quo_nxt);
      remainder = neg_r ? -rem_nxt : rem_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dvs   <= '0;
         quo   <= '0;
         rem   <= '0;
         cnt   <= '0;
         run   <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dvz   <= 1'b0;
      end else if (kill) begin
         run <= 1'b0;
         cnt <= '0;
      end else if (start) begin
         run   <= 1'b1;
         cnt   <= '0;
         rem   <= '0;
         quo   <= (sgn && a[31]) ? -a : a;
         dvs   <= (sgn && b[31]) ? -b : b;
         neg_q <= sgn && (a[31] ^ b[31]);
         neg_r <= sgn && a[31];
         dvz   <= (b == 32'd0);
      end else if (run) begin
         quo <= quo_nxt;
         rem <= rem_nxt;
         cnt <= cnt + 5'd1;
         if (valid) run <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
//   state | meaning
//   IDLE  | accepts MT* writes and issues MULT/MULTU/DIV/DIVU
//   MUL   | product travelling through the MUL_LAT delay line
//   DIV   | div_iter stepping one quotient bit per cycle
//   DONE  | result visible on hi/lo, instruction leaves EX
module ex_muldiv
   import mips_pkg::*;
#(
   parameter int MUL_LAT = 1
)
(
   input  logic       clk,
   input  logic       reset,
   ex_muldiv_if.slave bus
);

   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   md_state_t     state;
   md_state_t     state_nxt;
   logic [CW-1:0] mul_cnt;
   logic [63:0]   mul_pipe [MUL_LAT];
   logic [63:0]   mul_a;
   logic [63:0]   mul_b;
   logic [31:0]   hi_q;
   logic [31:0]   lo_q;
   logic          is_mul;
   logic          is_div;
   logic          issue;
   logic          div_start;
   logic          mul_last;
   logic          div_valid;
   logic [31:0]   div_q;
   logic [31:0]   div_r;

   always_comb begin
      is_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
      is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
      issue     = (state == ST_IDLE) && bus.start && (is_mul || is_div) && !bus.flush;
      div_start = issue && is_div;
      mul_last  = (mul_cnt == CW'(MUL_LAT - 1));
      mul_a     = (bus.op == OP_MULT) ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
      mul_b     = (bus.op == OP_MULT) ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
   end

   div_iter u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .sgn       (bus.op == OP_DIV),
      .a         (bus.a),
      .b         (bus.b),
      .kill      (bus.flush),
      .quotient  (div_q),
      .remainder (div_r),
      .valid     (div_valid)
   );

   // Stage 0 latches the product of the issued operands; later stages form the latency delay.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
      end else begin
         if (issue && is_mul) mul_pipe[0] <= mul_a * mul_b;
         for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                mul_cnt <= '0;
      else if (issue)           mul_cnt <= '0;
      else if (state == ST_MUL) mul_cnt <= mul_cnt + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (issue) state_nxt = is_mul ? ST_MUL : ST_DIV;
            ST_MUL:  if (mul_last) state_nxt = ST_DONE;
            ST_DIV:  if (div_valid) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (!bus.flush) begin
         if (state == ST_IDLE && bus.start && bus.op == OP_MTHI) hi_q <= bus.a;
         if (state == ST_IDLE && bus.start && bus.op == OP_MTLO) lo_q <= bus.a;
         if (state == ST_MUL && mul_last) {hi_q, lo_q} <= mul_pipe[MUL_LAT-1];
         if (state == ST_DIV && div_valid) begin
            hi_q <= div_r;
            lo_q <= div_q;
         end
      end
   end

   assign bus.busy = issue || (((state == ST_MUL) || (state == ST_DIV)) && !bus.flush);
   assign bus.done = (state == ST_DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed HI/LO operations, reset and flush cases.
module tb_ex_muldiv;
   import mips_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [63:0] exp_q [$];
   string       name_q [$];

   ex_muldiv_if m ();

   ex_muldiv #(.MUL_LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (m)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Holds start for the whole stall including DONE; ends at the negedge of the cycle after DONE.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int exp_busy, input string nm, input bit b2b);
      int nb  = 0;
      bit fin = 1'b0;
      exp_q.push_back({eh, el});
      name_q.push_back(nm);
      if (!b2b) @(negedge clk);
      m.start = 1'b1;
      m.op    = o;
      m.a     = x;
      m.b     = y;
      for (int c = 0; c < 80 && !fin; c++) begin
         #1;
         if (m.busy) nb++;
         if (m.done) fin = 1'b1;
         @(negedge clk);
      end
      m.start = 1'b0;
      m.op    = OP_NOP;
      chk({nm, " busy_cycles"}, 64'(nb), 64'(exp_busy));
      chk({nm, " done_seen"}, {63'd0, fin}, 64'd1);
   endtask

   initial begin : monitor
      logic [63:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         if (m.done === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", {63'd0, m.done}, 64'd0);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               chk({nm, " hi"}, {32'd0, m.hi}, {32'd0, e[63:32]});
               chk({nm, " lo"}, {32'd0, m.lo}, {32'd0, e[31:0]});
            end
         end
      end
   end

   initial begin : stimulus
      m.start = 1'b0;
      m.op    = OP_NOP;
      m.a     = '0;
      m.b     = '0;
      m.flush = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset hi",   {32'd0, m.hi}, 64'd0);
      chk("reset lo",   {32'd0, m.lo}, 64'd0);
      chk("reset busy", {63'd0, m.busy}, 64'd0);
      chk("reset done", {63'd0, m.done}, 64'd0);

      // MTHI then MTLO on consecutive cycles, no stall
      @(negedge clk);
      m.start = 1'b1; m.op = OP_MTHI; m.a = 32'h1234;
      #1;
      chk("mthi busy", {63'd0, m.busy}, 64'd0);
      chk("mthi hi_before_edge", {32'd0, m.hi}, 64'd0);
      @(negedge clk);
      chk("mthi hi", {32'd0, m.hi}, 64'h1234);
      m.op = OP_MTLO; m.a = 32'h5678;
      #1;
      chk("mtlo busy", {63'd0, m.busy}, 64'd0);
      @(negedge clk);
      m.start = 1'b0; m.op = OP_NOP;
      chk("mtlo lo", {32'd0, m.lo}, 64'h5678);
      chk("mtlo hi_kept", {32'd0, m.hi}, 64'h1234);

      // Reset at cycle 10 of a DIV
      @(negedge clk);
      m.start = 1'b1; m.op = OP_DIV; m.a = 32'd100; m.b = 32'd7;
      repeat (9) @(negedge clk);
      chk("pre_reset busy", {63'd0, m.busy}, 64'd1);
      #2;
      reset = 1'b1; m.start = 1'b0; m.op = OP_NOP;
      #1;
      chk("mid_reset busy", {63'd0, m.busy}, 64'd0);
      chk("mid_reset hi",   {32'd0, m.hi}, 64'd0);
      chk("mid_reset lo",   {32'd0, m.lo}, 64'd0);
      chk("mid_reset done", {63'd0, m.done}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op(OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         33, "divu_7_2",        1'b0);
      run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 2,  "mult_m2_3",       1'b0);
      run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3,         32'd2,         32'hFFFF_FFFA, 2,  "multu_b2b",       1'b1);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_m7_2",        1'b0);
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, "div_min_m1",      1'b0);
      run_op(OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 33, "divu_by_zero",    1'b0);
      run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, "div_m5_by_zero",  1'b0);
      run_op(OP_DIVU,  32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 33, "divu_max_16",     1'b0);
      run_op(OP_MULT,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 2,  "mult_7_m2",       1'b0);
      run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         2,  "multu_2p32",      1'b1);
      run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, "div_7_m2",        1'b1);

      // Flush at DIV cycle 20: no write, FSM back in IDLE (a following MTLO takes effect)
      @(negedge clk);
      m.start = 1'b1; m.op = OP_DIV; m.a = 32'd100; m.b = 32'd7;
      repeat (19) @(negedge clk);
      chk("pre_flush busy", {63'd0, m.busy}, 64'd1);
      m.flush = 1'b1;
      #1;
      chk("flush busy", {63'd0, m.busy}, 64'd0);
      @(negedge clk);
      m.flush = 1'b0;
      chk("flush hi_kept", {32'd0, m.hi}, 64'd1);
      chk("flush lo_kept", {32'd0, m.lo}, 64'hFFFF_FFFD);
      chk("flush done",    {63'd0, m.done}, 64'd0);
      m.op = OP_MTLO; m.a = 32'hAAAA;
      @(negedge clk);
      m.start = 1'b0; m.op = OP_NOP;
      chk("post_flush mtlo", {32'd0, m.lo}, 64'hAAAA);

      // Flush coincident with MTHI
      @(negedge clk);
      m.start = 1'b1; m.op = OP_MTHI; m.a = 32'hBEEF; m.flush = 1'b1;
      #1;
      chk("flush_mthi busy", {63'd0, m.busy}, 64'd0);
      @(negedge clk);
      m.start = 1'b0; m.op = OP_NOP; m.flush = 1'b0;
      chk("flush_mthi hi", {32'd0, m.hi}, 64'd1);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
